// File: rtl/inst_loader.sv
// Buffers a host program (valid/ready beats, ends on s_last) and replays it to the PE instruction memory.
// Latency: first im beat one cycle after the s_last handshake, then one beat per cycle with no bubbles.
// Backpressure: s_ready is low for the whole issue burst and execution window.
module inst_loader #(
    parameter int INST_WIDTH    = 64,
    parameter int IM_ADDR_WIDTH = 4,
    parameter int EXEC_EXTRA    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [INST_WIDTH-1:0]    s_inst,
    input  logic                     s_last,
    output logic                     im_valid,
    output logic [INST_WIDTH-1:0]    im_inst,
    output logic                     busy,
    output logic                     done,
    output logic                     err_ovf,
    output logic [IM_ADDR_WIDTH:0]   prog_len
);

    localparam int DEPTH = 2 ** IM_ADDR_WIDTH;
    localparam int CW    = IM_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, EXEC} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [INST_WIDTH-1:0]    mem [DEPTH];
    logic [IM_ADDR_WIDTH-1:0] wr_ptr;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_nxt;
    logic [CW-1:0]            rd_ptr;
    logic [8:0]               exec_cnt;
    logic [8:0]               exec_last;
    logic                     empty_done;
    logic                     accept;
    logic                     inst_nz;
    logic                     buf_full;
    logic                     do_write;
    logic                     ovf_drop;
    logic                     last_beat;
    logic                     prog_nonempty;
    logic                     issue_end;
    logic                     exec_end;

    assign s_ready       = (state == IDLE) || (state == LOAD);
    assign busy          = (state == ISSUE) || (state == EXEC);
    assign accept        = s_valid & s_ready;
    assign inst_nz       = |s_inst;
    assign buf_full      = (count == CW'(DEPTH));
    assign do_write      = accept & inst_nz & ~buf_full;
    assign ovf_drop      = accept & inst_nz & buf_full;
    assign count_nxt     = count + CW'(do_write);
    assign last_beat     = accept & s_last;
    assign prog_nonempty = (count_nxt != '0);
    assign issue_end     = (state == ISSUE) && (rd_ptr == prog_len);
    assign exec_last     = 9'(prog_len) + 9'(EXEC_EXTRA) - 9'd1;
    assign exec_end      = (state == EXEC) && (exec_cnt == exec_last);
    assign done          = empty_done | exec_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (last_beat) begin
                    state_nxt = prog_nonempty ? ISSUE : IDLE;
                end else if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (last_beat) begin
                    state_nxt = prog_nonempty ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                if (issue_end) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (exec_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Program storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= s_inst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            exec_cnt   <= '0;
            prog_len   <= '0;
            err_ovf    <= 1'b0;
            im_valid   <= 1'b0;
            im_inst    <= '0;
            empty_done <= 1'b0;
        end else begin
            empty_done <= last_beat & ~prog_nonempty;
            if (ovf_drop) begin
                err_ovf <= 1'b1;
            end
            if (do_write) begin
                wr_ptr <= wr_ptr + IM_ADDR_WIDTH'(1);
                count  <= count_nxt;
            end
            if (last_beat) begin
                prog_len <= count_nxt;
            end
            case (state)
                IDLE, LOAD: begin
                    // When the last beat is also the first stored one, bypass the buffer write.
                    if (last_beat && prog_nonempty) begin
                        im_valid <= 1'b1;
                        im_inst  <= (count == '0) ? s_inst : mem[0];
                        rd_ptr   <= CW'(1);
                    end
                end
                ISSUE: begin
                    if (issue_end) begin
                        im_valid <= 1'b0;
                        im_inst  <= '0;
                        exec_cnt <= '0;
                    end else begin
                        im_inst <= mem[rd_ptr[IM_ADDR_WIDTH-1:0]];
                        rd_ptr  <= rd_ptr + CW'(1);
                    end
                end
                EXEC: begin
                    if (exec_end) begin
                        wr_ptr   <= '0;
                        count    <= '0;
                        rd_ptr   <= '0;
                        exec_cnt <= '0;
                    end else begin
                        exec_cnt <= exec_cnt + 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: basic burst, zero filtering, overflow, empty program,
// input blocking while busy, back-to-back programs and asynchronous reset mid-burst.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_inst;
    logic        s_last;
    logic        im_valid;
    logic [63:0] im_inst;
    logic        busy;
    logic        done;
    logic        err_ovf;
    logic [4:0]  prog_len;

    int checks = 0;
    int failures = 0;

    logic [63:0] burst[$];
    int          n_exec;
    int          done_cyc;
    bit          saw_aa;
    bit          rdy_bad;
    bit          idle_bad;

    inst_loader #(.INST_WIDTH(64), .IM_ADDR_WIDTH(4), .EXEC_EXTRA(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_inst(s_inst), .s_last(s_last), .im_valid(im_valid), .im_inst(im_inst),
        .busy(busy), .done(done), .err_ovf(err_ovf), .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input bit last);
        s_valid = 1'b1;
        s_inst  = d;
        s_last  = last;
        for (int w = 0; w < 100 && !s_ready; w++) tick();
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_wait_ready got=%b exp=1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_inst  = '0;
        s_last  = 1'b0;
    endtask

    // Called right after the last handshake; returns sampled in the done cycle.
    task automatic capture(input bit spam);
        burst.delete();
        n_exec   = 0;
        done_cyc = -1;
        saw_aa   = 1'b0;
        rdy_bad  = 1'b0;
        idle_bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (spam) begin
                s_valid = 1'b1;
                s_inst  = 64'hAA;
                s_last  = 1'b0;
            end
            if (im_valid) begin
                burst.push_back(im_inst);
            end else begin
                if (im_inst !== 64'h0) idle_bad = 1'b1;
                if (busy) n_exec++;
            end
            if (im_inst === 64'hAA) saw_aa = 1'b1;
            if (busy && s_ready) rdy_bad = 1'b1;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        s_inst  = '0;
        s_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_inst = '0; s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (im_valid !== 1'b0) begin failures++; $display("FAIL reset_im_valid got=%b exp=0", im_valid); end
        checks++; if (im_inst !== 64'h0) begin failures++; $display("FAIL reset_im_inst got=%h exp=0", im_inst); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL reset_err_ovf got=%b exp=0", err_ovf); end
        checks++; if (prog_len !== 5'd0) begin failures++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
        rst_n = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_basic();
        logic [63:0] exp_b[3];
        exp_b = '{64'h11, 64'h22, 64'h33};
        send(64'h11, 1'b0);
        send(64'h22, 1'b0);
        send(64'h33, 1'b1);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_drop got=%b exp=0", s_ready); end
        capture(1'b0);
        checks++; if (burst.size() != 3) begin failures++; $display("FAIL basic_burst_len got=%0d exp=3", burst.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++;
            if (burst[i] !== exp_b[i]) begin failures++; $display("FAIL basic_beat%0d got=%h exp=%h", i, burst[i], exp_b[i]); end
        end
        checks++; if (n_exec != 7) begin failures++; $display("FAIL basic_exec_cycles got=%0d exp=7", n_exec); end
        checks++; if (done_cyc != 9) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=9", done_cyc); end
        checks++; if (idle_bad) begin failures++; $display("FAIL basic_exec_inst got=nonzero exp=0"); end
        checks++; if (prog_len !== 5'd3) begin failures++; $display("FAIL basic_prog_len got=%0d exp=3", prog_len); end
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after_done got=%b exp=1", s_ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_zero_filter();
        send(64'h5, 1'b0);
        send(64'h0, 1'b0);
        send(64'h0, 1'b0);
        send(64'h7, 1'b1);
        capture(1'b0);
        checks++; if (burst.size() != 2) begin failures++; $display("FAIL zero_burst_len got=%0d exp=2", burst.size()); end
        else begin
            checks++; if (burst[0] !== 64'h5) begin failures++; $display("FAIL zero_beat0 got=%h exp=5", burst[0]); end
            checks++; if (burst[1] !== 64'h7) begin failures++; $display("FAIL zero_beat1 got=%h exp=7", burst[1]); end
        end
        checks++; if (prog_len !== 5'd2) begin failures++; $display("FAIL zero_prog_len got=%0d exp=2", prog_len); end
        checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL zero_err_ovf got=%b exp=0", err_ovf); end
        checks++; if (n_exec != 6) begin failures++; $display("FAIL zero_exec_cycles got=%0d exp=6", n_exec); end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 18; i++) send(64'(i), i == 18);
        capture(1'b0);
        checks++; if (burst.size() != 16) begin failures++; $display("FAIL ovf_burst_len got=%0d exp=16", burst.size()); end
        else for (int i = 0; i < 16; i++) begin
            checks++;
            if (burst[i] !== 64'(i + 1)) begin failures++; $display("FAIL ovf_beat%0d got=%h exp=%h", i, burst[i], 64'(i + 1)); end
        end
        checks++; if (prog_len !== 5'd16) begin failures++; $display("FAIL ovf_prog_len got=%0d exp=16", prog_len); end
        checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_err_ovf got=%b exp=1", err_ovf); end
        checks++; if (n_exec != 20) begin failures++; $display("FAIL ovf_exec_cycles got=%0d exp=20", n_exec); end
        tick();
    endtask

    task automatic test_empty();
        send(64'h0, 1'b1);
        capture(1'b0);
        checks++; if (burst.size() != 0) begin failures++; $display("FAIL empty_burst_len got=%0d exp=0", burst.size()); end
        checks++; if (done_cyc != 0) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=0", done_cyc); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy got=%b exp=0", busy); end
        checks++; if (prog_len !== 5'd0) begin failures++; $display("FAIL empty_prog_len got=%0d exp=0", prog_len); end
        checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL empty_err_ovf_sticky got=%b exp=1", err_ovf); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL empty_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_back_to_back();
        send(64'h0A, 1'b0);
        send(64'h0B, 1'b1);
        capture(1'b1);
        checks++; if (rdy_bad) begin failures++; $display("FAIL b2b_ready_while_busy got=1 exp=0"); end
        checks++; if (saw_aa) begin failures++; $display("FAIL b2b_aa_leak got=1 exp=0"); end
        checks++; if (burst.size() != 2) begin failures++; $display("FAIL b2b_first_len got=%0d exp=2", burst.size()); end
        else begin
            checks++; if (burst[1] !== 64'h0B) begin failures++; $display("FAIL b2b_first_beat1 got=%h exp=0b", burst[1]); end
        end
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_done got=%b exp=1", s_ready); end
        send(64'h3C, 1'b0);
        send(64'h4D, 1'b1);
        capture(1'b0);
        checks++; if (burst.size() != 2) begin failures++; $display("FAIL b2b_second_len got=%0d exp=2", burst.size()); end
        else begin
            checks++; if (burst[0] !== 64'h3C) begin failures++; $display("FAIL b2b_second_beat0 got=%h exp=3c", burst[0]); end
            checks++; if (burst[1] !== 64'h4D) begin failures++; $display("FAIL b2b_second_beat1 got=%h exp=4d", burst[1]); end
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        send(64'h61, 1'b0);
        send(64'h62, 1'b0);
        send(64'h63, 1'b1);
        tick();
        checks++; if (im_inst !== 64'h62) begin failures++; $display("FAIL rst_second_beat got=%h exp=62", im_inst); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (im_valid !== 1'b0) begin failures++; $display("FAIL rst_async_im_valid got=%b exp=0", im_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        checks++; if (im_inst !== 64'h0) begin failures++; $display("FAIL rst_async_im_inst got=%h exp=0", im_inst); end
        checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL rst_async_err_ovf got=%b exp=0", err_ovf); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_idle_ready got=%b exp=1", s_ready); end
        checks++; if (im_valid !== 1'b0) begin failures++; $display("FAIL rst_idle_im_valid got=%b exp=0", im_valid); end
        send(64'h71, 1'b0);
        send(64'h72, 1'b1);
        capture(1'b0);
        checks++; if (burst.size() != 2) begin failures++; $display("FAIL rst_new_len got=%0d exp=2", burst.size()); end
        else begin
            checks++; if (burst[0] !== 64'h71) begin failures++; $display("FAIL rst_new_beat0 got=%h exp=71", burst[0]); end
            checks++; if (burst[1] !== 64'h72) begin failures++; $display("FAIL rst_new_beat1 got=%h exp=72", burst[1]); end
        end
        checks++; if (prog_len !== 5'd2) begin failures++; $display("FAIL rst_new_prog_len got=%0d exp=2", prog_len); end
        checks++; if (done_cyc != 7) begin failures++; $display("FAIL rst_new_done_cycle got=%0d exp=7", done_cyc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_filter();
        test_overflow();
        test_empty();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
